clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Runtime-reconfigurable clock divider with a two-requester configuration arbiter. It generates a divided square wave and a once-per-period tick from `clk_in`. Two independent requesters can change the divide ratio through valid/ready handshakes. Arbitration is round-robin, and a new ratio takes effect only at a period boundary, so `clk_out` never emits a truncated or glitched period.

## Interface
- `WIDTH`, 23: width of the counter and of all divide-ratio values.
- `DEFAULT_DIV`, 2: divide ratio loaded at reset; must be >= 2.

- `clk_in`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a new ratio on `req0_div`.
- `req0_div`  in  WIDTH  requested ratio from requester 0.
- `req0_ready`  out  1  requester 0 granted; a transfer occurs when `req0_valid && req0_ready`.
- `req1_valid`, `req1_div`, `req1_ready`: same as requester 0, for requester 1.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse per period, registered.
- `cur_div`  out  WIDTH  ratio currently in effect.
- `busy`  out  1  an accepted ratio is pending application.
- `err`  out  1  one-cycle pulse when an accepted ratio is rejected.

## Operation
- Counter `cnt` (WIDTH bits) runs 1..`cur_div`.
  - Each cycle: if `cnt >= cur_div`, then `cnt <= 1`; otherwise `cnt <= cnt+1`.
  - `cnt` never exceeds `cur_div`, so there is no overflow for any `cur_div <= 2^WIDTH-1`.
- Per-cycle registered outputs, computed from the pre-update `cnt` and `cur_div`:
  - `clk_out <= (cnt > cur_div>>1)`. Low for floor(div/2) cycles, high for ceil(div/2) cycles.
  - `tick <= (cnt >= cur_div)`.
- FSM states:
  - IDLE:
    - Ready is combinational: `req0_ready = IDLE && req0_valid && (!req1_valid || rr==0)`; `req1_ready` is symmetric with `rr==1`.
    - Valid low gives ready low.
    - On transfer: `rr` toggles to the other requester. If the accepted div >= 2, latch it into `pend_div` and go to PEND. If the accepted div < 2, pulse `err` next cycle and stay in IDLE.
  - PEND:
    - Both readies are 0 and `busy`=1.
    - On the first cycle with `cnt >= cur_div`: `cur_div <= pend_div`, `cnt <= 1`, go to IDLE.
    - The `clk_out`/`tick` computed in that cycle use the old `cur_div`.
- `rr` changes only on a transfer, never on idle cycles.
- An accept in the same cycle as a wrap goes to PEND and applies at the next wrap, not the current one.
- Requester data is sampled only on the transfer cycle.
  - Holding valid with ready low is legal.
  - A requester may change `reqN_div` while waiting.
- Reset values:
  - `cnt`=1, `cur_div`=`DEFAULT_DIV`, `pend_div`=0, state IDLE, `rr`=0.
  - `clk_out`=0, `tick`=0, `err`=0, `busy`=0.
- Reset asserted in PEND discards the pending ratio.

## Timing
- Accept-to-apply latency: `cur_div` updates on the clock edge that ends the current period. The wait is 1..old `cur_div` cycles after the transfer edge.
- The first `clk_out` cycle driven by the new ratio is the one after the new period's `cnt`=1 cycle.
- `err` is high for exactly the cycle after the rejected transfer.
- `busy` goes high the cycle after the transfer and drops with the `cur_div` update.
- Throughput: at most one ratio change per period. The minimum spacing between transfers is one period plus one cycle.
- `tick` period equals `cur_div` cycles in steady state.
- `clk_out` and `tick` are registered and glitch-free.

## Test plan
- Reset, then run with `DEFAULT_DIV`=2 -> `clk_out` = 0,1,0,1…; `tick` every 2nd cycle; `cur_div`=2; both readies 0 with no valid.
- `req0_div`=5 pulsed mid-period -> `busy`=1 until the next wrap; then `cur_div`=5, `clk_out` low 2 cycles and high 3, `tick` every 5 cycles; `rr`=1.
- `req0_valid`=`req1_valid`=1 with `rr`=0, `req0_div`=4, `req1_div`=6 -> `req0_ready` first and 4 is applied. Then `req1` is granted in the IDLE cycle after the update, and 6 is applied at the following wrap.
- Accepted `req1_div`=1, then `req1_div`=0 -> `err` pulses once for each; `cur_div` unchanged; no PEND entry; `rr` still toggles per transfer.
- `rst` asserted in PEND with `pend_div`=9 -> all outputs return to reset values asynchronously; after release the period equals `DEFAULT_DIV`, never 9.
- Set `WIDTH`=4 and apply `req0_div`=15 -> period 15 (low 7, high 8); the counter reaches 15 and wraps to 1 with no overflow.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Request/status bundle for clk_div_ctrl: two ratio requesters plus divider outputs.
// Latency: none (pure wiring).
// Backpressure: reqN_ready is the only flow control; a transfer is reqN_valid && reqN_ready.
//
// Ports (signals):
//   req0_valid/req0_div/req0_ready : requester 0 handshake and requested ratio
//   req1_valid/req1_div/req1_ready : requester 1 handshake and requested ratio
//   clk_out, tick                  : divided clock and once-per-period pulse
//   cur_div, busy, err             : ratio in effect, change pending, rejected ratio pulse
interface clk_div_ctrl_if #(
    parameter int WIDTH = 23
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_div;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_div;
    logic             req1_ready;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             busy;
    logic             err;

    // Requester side plus anything observing the divider outputs.
    modport master (
        output req0_valid, req0_div, req1_valid, req1_div,
        input  req0_ready, req1_ready, clk_out, tick, cur_div, busy, err
    );

    // The divider itself.
    modport slave (
        input  req0_valid, req0_div, req1_valid, req1_div,
        output req0_ready, req1_ready, clk_out, tick, cur_div, busy, err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Runtime-reconfigurable clock divider with a round-robin two-requester ratio arbiter.
// Latency: clk_out/tick registered (1 cycle); an accepted ratio applies at the end of the current period.
// Backpressure: readies are held low while a ratio is pending, so at most one change per period.
//
// Ports:
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   bus    : clk_div_ctrl_if.slave (requester handshakes, clk_out, tick, cur_div, busy, err)
module clk_div_ctrl #(
    parameter int WIDTH       = 23,
    parameter int DEFAULT_DIV = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             clk_out_q;
    logic             tick_q;
    logic             err_q, err_d;

    logic             wrap;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] acc_div;

    // The counter never exceeds cur_div, so >= is equivalent to == here; >= keeps the
    // wrap safe even if the compare ever sees a stale larger count.
    assign wrap = (cnt_q >= cur_div_q);

    // rr names the requester that wins a tie; a lone valid requester always wins.
    assign gnt0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !rr_q);
    assign gnt1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid ||  rr_q);
    assign acc_div = gnt0 ? bus.req0_div : bus.req1_div;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        err_d      = 1'b0;
        cnt_d      = wrap ? ONE : (cnt_q + ONE);

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    rr_d = ~rr_q;
                    // Ratios below 2 cannot form a square wave; drop them and flag it.
                    if (acc_div >= MIN_DIV) begin
                        pend_div_d = acc_div;
                        state_d    = PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PEND: begin
                // Swap the ratio only on the period boundary so no period is truncated.
                if (wrap) begin
                    cur_div_d = pend_div_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            cnt_q      <= ONE;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            // Both use the pre-update count and ratio: low for floor(div/2), high for ceil(div/2).
            clk_out_q  <= (cnt_q > (cur_div_q >> 1));
            tick_q     <= wrap;
            err_q      <= err_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.clk_out    = clk_out_q;
    assign bus.tick       = tick_q;
    assign bus.cur_div    = cur_div_q;
    assign bus.busy       = (state_q == PEND);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: table-driven vectors, hand sequences and random traffic
// against a period-level reference model; a second 4-bit instance covers the widest ratio.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_clk_div_ctrl;
    localparam int W  = 23;
    localparam int W4 = 4;

    logic clk_in;
    logic rst;

    clk_div_ctrl_if #(.WIDTH(W))  bus  ();
    clk_div_ctrl_if #(.WIDTH(W4)) bus4 ();

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    clk_div_ctrl #(.WIDTH(W4), .DEFAULT_DIV(2)) dut4 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus4)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position within the current period (1..period), the period in effect, a queue of
    // accepted-but-not-yet-applied ratios, and whose turn it is on a tie.
    int m_pos, m_period, m_turn;
    int m_q[$];
    bit exp_clk, exp_tick, exp_err;
    bit m_g0, m_g1;
    bit in_v0, in_v1;
    int in_d0, in_d1;
    bit s_err;

    task automatic model_reset();
        m_pos    = 1;
        m_period = 2;
        m_turn   = 0;
        m_q.delete();
        exp_clk  = 0;
        exp_tick = 0;
        exp_err  = 0;
    endtask

    task automatic drive(input bit v0, input int d0, input bit v1, input int d1);
        in_v0 = v0; in_d0 = d0; in_v1 = v1; in_d1 = d1;
        bus.req0_valid = v0;
        bus.req0_div   = W'(d0);
        bus.req1_valid = v1;
        bus.req1_div   = W'(d1);
    endtask

    // Called at the falling edge: compare everything, then advance one cycle.
    task automatic model_eval();
        bit idle;
        bit last;
        int acc;
        idle = (m_q.size() == 0);
        m_g0 = idle && in_v0 && (!in_v1 || m_turn == 0);
        m_g1 = idle && in_v1 && (!in_v0 || m_turn == 1);
        chk("clk_out",    int'(bus.clk_out),    int'(exp_clk));
        chk("tick",       int'(bus.tick),       int'(exp_tick));
        chk("err",        int'(bus.err),        int'(exp_err));
        chk("busy",       int'(bus.busy),       int'(!idle));
        chk("cur_div",    int'(bus.cur_div),    m_period);
        chk("req0_ready", int'(bus.req0_ready), int'(m_g0));
        chk("req1_ready", int'(bus.req1_ready), int'(m_g1));
        s_err = bus.err;

        last     = (m_pos == m_period);
        exp_clk  = (2 * m_pos > m_period);
        exp_tick = last;
        exp_err  = 0;
        if (last) begin
            m_pos = 1;
            if (m_q.size() != 0) m_period = m_q.pop_front();
        end else begin
            m_pos++;
        end
        if (m_g0 || m_g1) begin
            m_turn = 1 - m_turn;
            acc    = m_g0 ? in_d0 : in_d1;
            if (acc >= 2) m_q.push_back(acc);
            else          exp_err = 1;
        end
    endtask

    task automatic step(input bit v0, input int d0, input bit v1, input int d1);
        drive(v0, d0, v1, d1);
        @(negedge clk_in);
        model_eval();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v0; int d0; bit v1; int d1;
        bit clk; bit tick; bit r0; bit r1; bit busy; int cur;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int  errcnt;
        int  first_gnt;
        bit  done0, done1;
        bit  seen;
        int  stage;
        int  j;

        tbl[0]  = '{0,0,0,0, 0,0,0,0,0,2};
        tbl[1]  = '{0,0,0,0, 0,0,0,0,0,2};
        tbl[2]  = '{0,0,0,0, 1,1,0,0,0,2};
        tbl[3]  = '{1,5,0,0, 0,0,1,0,0,2};   // accept 5 in a wrap cycle
        tbl[4]  = '{0,0,0,0, 1,1,0,0,1,2};
        tbl[5]  = '{0,0,0,0, 0,0,0,0,1,2};   // applies at this wrap, not the previous one
        tbl[6]  = '{0,0,0,0, 1,1,0,0,0,5};
        tbl[7]  = '{0,0,0,0, 0,0,0,0,0,5};
        tbl[8]  = '{0,0,0,0, 0,0,0,0,0,5};
        tbl[9]  = '{0,0,0,0, 1,0,0,0,0,5};
        tbl[10] = '{0,0,0,0, 1,0,0,0,0,5};
        tbl[11] = '{0,0,0,0, 1,1,0,0,0,5};
        tbl[12] = '{1,7,1,3, 0,0,0,1,0,5};   // rr now points at requester 1
        tbl[13] = '{0,0,0,0, 0,0,0,0,1,5};
        tbl[14] = '{0,0,0,0, 1,0,0,0,1,5};
        tbl[15] = '{0,0,0,0, 1,0,0,0,1,5};
        tbl[16] = '{0,0,0,0, 1,1,0,0,0,3};
        tbl[17] = '{0,0,0,0, 0,0,0,0,0,3};
        tbl[18] = '{0,0,0,0, 1,0,0,0,0,3};
        tbl[19] = '{0,0,0,0, 1,1,0,0,0,3};

        bus4.req0_valid = 0; bus4.req0_div = '0;
        bus4.req1_valid = 0; bus4.req1_div = '0;
        drive(0, 0, 0, 0);
        rst = 1;
        repeat (3) @(posedge clk_in);
        #1;
        rst = 0;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            @(negedge clk_in);
            chk($sformatf("tbl%0d_clk", i),  int'(bus.clk_out),    int'(tbl[i].clk));
            chk($sformatf("tbl%0d_tick", i), int'(bus.tick),       int'(tbl[i].tick));
            chk($sformatf("tbl%0d_r0", i),   int'(bus.req0_ready), int'(tbl[i].r0));
            chk($sformatf("tbl%0d_r1", i),   int'(bus.req1_ready), int'(tbl[i].r1));
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy),       int'(tbl[i].busy));
            chk($sformatf("tbl%0d_cur", i),  int'(bus.cur_div),    tbl[i].cur);
            model_eval();
            @(posedge clk_in);
            #1;
        end

        // Simultaneous requests with rr back at requester 0: 4 first, then 6.
        done0 = 0; done1 = 0; first_gnt = -1;
        for (int i = 0; i < 60 && !(done0 && done1); i++) begin
            step(!done0, 4, !done1, 6);
            if (m_g0 && !done0) begin done0 = 1; if (first_gnt < 0) first_gnt = 0; end
            if (m_g1 && !done1) begin done1 = 1; if (first_gnt < 0) first_gnt = 1; end
        end
        chk("arb_first_grant", first_gnt, 0);
        chk("arb_both_granted", int'(done0 && done1), 1);
        repeat (12) step(0, 0, 0, 0);
        chk("arb_final_div", int'(bus.cur_div), 6);

        // Rejected ratios 1 then 0 from requester 1.
        errcnt = 0; stage = 0;
        for (int i = 0; i < 40 && stage < 2; i++) begin
            step(0, 0, 1, (stage == 0) ? 1 : 0);
            if (s_err) errcnt++;
            if (m_g1) stage++;
        end
        repeat (3) begin
            step(0, 0, 0, 0);
            if (s_err) errcnt++;
        end
        chk("err_pulses", errcnt, 2);
        chk("err_div_kept", int'(bus.cur_div), 6);
        step(1, 3, 1, 8);     // two toggles leave rr at requester 0
        repeat (10) step(0, 0, 0, 0);

        // Random traffic, including illegal ratios and valids that come and go.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 9),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 9));
        end

        // Reset while a ratio of 9 is pending.
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1, 9, 0, 0);
            seen = m_g0;
        end
        chk("rst_pend_accept", int'(seen), 1);
        chk("rst_pend_busy", int'(bus.busy), int'(m_q.size() != 0));
        rst = 1;
        #1;
        chk("rst_clk_out", int'(bus.clk_out), 0);
        chk("rst_tick",    int'(bus.tick),    0);
        chk("rst_err",     int'(bus.err),     0);
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_cur_div", int'(bus.cur_div), 2);
        drive(0, 0, 0, 0);
        @(posedge clk_in);
        #1;
        rst = 0;
        model_reset();
        repeat (14) step(0, 0, 0, 0);

        // 4-bit instance: largest ratio 15, low 7 / high 8, counter wraps without overflow.
        bus4.req0_valid = 1;
        bus4.req0_div   = 4'd15;
        @(negedge clk_in);
        chk("w4_ready", int'(bus4.req0_ready), 1);
        @(posedge clk_in);
        #1;
        bus4.req0_valid = 0;
        bus4.req0_div   = 4'd0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            seen = (bus4.cur_div == 4'd15);
        end
        chk("w4_apply", int'(seen), 1);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_in);
            j = ((n - 1) % 15) + 1;
            chk($sformatf("w4_clk_%0d", n),  int'(bus4.clk_out), int'(j > 7));
            chk($sformatf("w4_tick_%0d", n), int'(bus4.tick),    int'(j == 15));
            chk($sformatf("w4_cur_%0d", n),  int'(bus4.cur_div), 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
